// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
//
// Registered immediate-extension stage between instruction decode and the
// ID/EX boundary. The raw IN_W-bit immediate is extended to OUT_W bits on the
// input side (sign, zero, upper/LUI, optionally branch offset). The extended
// value is then held behind a valid/ready handshake that uses a 2-entry skid
// buffer (output register + one skid register).
//
// Optional feature macro: IMM_BRANCH_MODE_EN
//   defined   : MODE=11 yields sign-extend then shift-left-2 (branch offset)
//   undefined : MODE=11 behaves as sign-extend and no shifter is built
//
// Parameters:
//   IN_W  - immediate field width, legal range 1..OUT_W-2
//   OUT_W - extended output width
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   synchronous active-high reset (highest priority)
//   FLUSH      in   synchronous pipeline flush; empties both entries and
//                   drops any input offered in the same cycle
//   IN_VALID   in   IMM/MODE valid this cycle
//   IN_READY   out  stage can accept (skid register empty, not in reset)
//   IMM        in   raw immediate field [IN_W-1:0]
//   MODE       in   00 sign, 01 zero, 10 upper, 11 branch
//   OUT_VALID  out  OUT holds a valid extended value
//   OUT_READY  in   consumer accepts OUT this cycle
//   OUT        out  extended immediate [OUT_W-1:0]
// -----------------------------------------------------------------------------
module imm_extend_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  IMM,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OUT
);

  // ---------------------------------------------------------------------------
  // Extension datapath (purely combinational, input side)
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] sext_value;
  logic [OUT_W-1:0] zext_value;
  logic [OUT_W-1:0] upper_value;
  logic [OUT_W-1:0] ext_value;

  // Bit-wise sign extension: low bits copy IMM, the rest replicate its MSB.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_sext
    if (gi < IN_W) begin : g_copy
      assign sext_value[gi] = IMM[gi];
    end else begin : g_sign
      assign sext_value[gi] = IMM[IN_W-1];
    end
  end

  assign zext_value  = {{(OUT_W-IN_W){1'b0}}, IMM};
  assign upper_value = {IMM, {(OUT_W-IN_W){1'b0}}};

  always_comb begin
    ext_value = sext_value;
    case (MODE)
      2'b01:   ext_value = zext_value;
      2'b10:   ext_value = upper_value;
`ifdef IMM_BRANCH_MODE_EN
      // Branch offset: the two top sign bits fall off the left end.
      2'b11:   ext_value = {sext_value[OUT_W-3:0], 2'b00};
`endif
      default: ext_value = sext_value;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Skid buffer state
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] out_data_reg,  out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic [OUT_W-1:0] skid_data_reg, skid_data_next;
  logic             skid_valid_reg, skid_valid_next;

  logic in_fire;
  logic out_fire;

  // Ready depends only on stored state (and reset), never on OUT_READY, so
  // no combinational path runs from the consumer back to the producer.
  assign IN_READY  = !skid_valid_reg && !RST;
  assign OUT_VALID = out_valid_reg;
  assign OUT       = out_data_reg;

  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = out_valid_reg && OUT_READY;

  always_comb begin
    out_data_next   = out_data_reg;
    out_valid_next  = out_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_valid_next = skid_valid_reg;

    if (FLUSH) begin
      // Both entries are discarded; data registers keep stale contents and
      // any input offered this cycle is ignored.
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!out_valid_reg || out_fire) begin
      // Output register is free (empty or draining this edge).
      if (skid_valid_reg) begin
        // Oldest entry lives in skid; keep FIFO order. IN_READY is low here,
        // so no input can arrive in the same cycle.
        out_data_next   = skid_data_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (in_fire) begin
        out_data_next  = ext_value;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (in_fire) begin
      // Output stalled and occupied: park the new value in skid.
      skid_data_next  = ext_value;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
    end else begin
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_stage
//
// Self-checking bench for imm_extend_stage. A table of mode vectors is applied
// back-to-back, followed by hand-written sequences for reset, back-pressure,
// full throughput, flush, reset mid-stall and a narrow parameter set.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imm_extend_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  // Narrow instance for the parameter sweep
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  imm8;
  logic [1:0]  mode8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] out_data8;

  int checks   = 0;
  int failures = 0;

  imm_extend_stage #(.IN_W(16), .OUT_W(32)) u_dut (
    .CLK       (clk),
    .RST       (rst),
    .FLUSH     (flush),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IMM       (imm),
    .MODE      (mode),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT       (out_data)
  );

  imm_extend_stage #(.IN_W(8), .OUT_W(16)) u_dut8 (
    .CLK       (clk),
    .RST       (rst),
    .FLUSH     (flush),
    .IN_VALID  (in_valid8),
    .IN_READY  (in_ready8),
    .IMM       (imm8),
    .MODE      (mode8),
    .OUT_VALID (out_valid8),
    .OUT_READY (out_ready8),
    .OUT       (out_data8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s got=%h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int idx;
  int exp_val;
  int got_cnt;
  logic acc;

  initial begin
    // ---------------- vector table ----------------
    vecs[0]  = '{"sign_8001",  16'h8001, 2'b00, 32'hFFFF8001};
    vecs[1]  = '{"zero_8001",  16'h8001, 2'b01, 32'h00008001};
    vecs[2]  = '{"upper_8001", 16'h8001, 2'b10, 32'h80010000};
`ifdef IMM_BRANCH_MODE_EN
    vecs[3]  = '{"br_8001",    16'h8001, 2'b11, 32'hFFFE0004};
    vecs[4]  = '{"br_0001",    16'h0001, 2'b11, 32'h00000004};
    vecs[5]  = '{"br_7fff",    16'h7FFF, 2'b11, 32'h0001FFFC};
    vecs[6]  = '{"br_ffff",    16'hFFFF, 2'b11, 32'hFFFFFFFC};
`else
    vecs[3]  = '{"br_8001",    16'h8001, 2'b11, 32'hFFFF8001};
    vecs[4]  = '{"br_0001",    16'h0001, 2'b11, 32'h00000001};
    vecs[5]  = '{"br_7fff",    16'h7FFF, 2'b11, 32'h00007FFF};
    vecs[6]  = '{"br_ffff",    16'hFFFF, 2'b11, 32'hFFFFFFFF};
`endif
    vecs[7]  = '{"sign_7fff",  16'h7FFF, 2'b00, 32'h00007FFF};
    vecs[8]  = '{"upper_7fff", 16'h7FFF, 2'b10, 32'h7FFF0000};
    vecs[9]  = '{"zero_ffff",  16'hFFFF, 2'b01, 32'h0000FFFF};
    vecs[10] = '{"sign_0000",  16'h0000, 2'b00, 32'h00000000};
    vecs[11] = '{"sign_ffff",  16'hFFFF, 2'b00, 32'hFFFFFFFF};

    // ---------------- reset with IN_VALID high ----------------
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b1; imm = 16'h8001; mode = 2'b00; out_ready = 1'b1;
    in_valid8 = 1'b0; imm8 = 8'h00; mode8 = 2'b00; out_ready8 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out",       out_data,           32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("rst_release_out_valid", {31'd0, out_valid}, 32'd0);

    // ---------------- mode table, back-to-back ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; imm = vecs[i].imm; mode = vecs[i].mode;
      step();
      check({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check(vecs[i].name, out_data, vecs[i].exp);
    end
    in_valid = 1'b0;
    step();
    check("table_drain_valid", {31'd0, out_valid}, 32'd0);

    // ---------------- back-pressure ----------------
    out_ready = 1'b0; mode = 2'b01; idx = 1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; imm = idx[15:0];
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
      if (c == 1) check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      if (c >= 1) begin
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_out",   out_data,           32'd1);
      end
    end
    check("bp_accepted_two", idx, 3);
    out_ready = 1'b1; exp_val = 1; got_cnt = 0;
    for (int c = 0; c < 20 && got_cnt < 5; c++) begin
      if (idx <= 5) begin
        in_valid = 1'b1; imm = idx[15:0];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("bp_order_%0d", exp_val), out_data, exp_val);
        exp_val++;
        got_cnt++;
      end
      step();
      if (acc) idx++;
    end
    check("bp_count", got_cnt, 5);
    in_valid = 1'b0;
    step();
    check("bp_empty_after", {31'd0, out_valid}, 32'd0);

    // ---------------- full throughput ----------------
    out_ready = 1'b1; mode = 2'b01;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; imm = 16'h0010 + c[15:0];
      check($sformatf("tp_in_ready_%0d", c), {31'd0, in_ready}, 32'd1);
      step();
      check($sformatf("tp_valid_%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("tp_out_%0d", c), out_data, 32'h10 + c);
    end
    in_valid = 1'b0;
    step();
    check("tp_drain_valid", {31'd0, out_valid}, 32'd0);

    // ---------------- flush with two entries held ----------------
    out_ready = 1'b0; mode = 2'b00;
    in_valid = 1'b1; imm = 16'h000A; step();
    imm = 16'h000B; step();
    check("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; imm = 16'h1234; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid",  {31'd0, out_valid}, 32'd0);
    check("fl_in_ready",   {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("fl_stays_empty", {31'd0, out_valid}, 32'd0);
    end

    // ---------------- flush drops input even while ready ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h000C; step();
    check("fl1_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b1; imm = 16'h1234;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl1_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("fl1_dropped", {31'd0, out_valid}, 32'd0);

    // ---------------- reset mid-stall ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h0021; step();
    imm = 16'h0022; step();
    rst = 1'b1;
    step();
    check("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check("rs_out",       out_data,           32'd0);
    check("rs_in_ready",  {31'd0, in_ready},  32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rs_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("rs_release_empty", {31'd0, out_valid}, 32'd0);

    // ---------------- parameter sweep: IN_W=8, OUT_W=16 ----------------
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; imm8 = 8'hF0; mode8 = 2'b00; step();
    check("p8_sign",  {16'd0, out_data8}, 32'h0000FFF0);
    mode8 = 2'b10; step();
    check("p8_upper", {16'd0, out_data8}, 32'h0000F000);
    mode8 = 2'b01; step();
    check("p8_zero",  {16'd0, out_data8}, 32'h000000F0);
    mode8 = 2'b11; step();
`ifdef IMM_BRANCH_MODE_EN
    check("p8_branch", {16'd0, out_data8}, 32'h0000FFC0);
`else
    check("p8_branch", {16'd0, out_data8}, 32'h0000FFF0);
`endif
    check("p8_valid", {31'd0, out_valid8}, 32'd1);
    in_valid8 = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
